// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite response codes, FSM state encodings and bus widths
package axil_pkg;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;
endpackage

// File: rtl/axil_ram_bank.sv
// axil_ram_bank: word-wide RAM with a byte-enabled write port and a read-before-write registered read port
module axil_ram_bank
  import axil_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [STRB_W-1:0]              wstrb,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [DATA_W-1:0]              rdata
);
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  // write only the enabled byte lanes; contents survive reset
  always_ff @(posedge clk)
    if (we)
      for (int b = 0; b < STRB_W; b++)
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
  // nonblocking read of the array returns the old word when a write hits the same edge
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/axil_ram_responder.sv
// axil_ram_responder: AXI4-Lite RAM responder with independent single-outstanding read and write FSMs
module axil_ram_responder
  import axil_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [31:0]       ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY
);
  localparam int IW = $clog2(DEPTH_WORDS);
  w_state_e          w_state;
  r_state_e          r_state;
  logic [31:0]       aw_addr;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic [29:0]       aw_word, ar_word;
  logic              aw_ok, ar_ok, rd_en, r_err;
  logic [DATA_W-1:0] ram_q;
  // addresses below BASE_ADDR wrap to huge word indices and so fall out of range
  always_comb begin
    aw_word = 30'((aw_addr - BASE_ADDR) >> 2);
    ar_word = 30'((ARADDR - BASE_ADDR) >> 2);
    aw_ok = aw_word < 30'(DEPTH_WORDS);
    ar_ok = ar_word < 30'(DEPTH_WORDS);
    rd_en = r_state == R_IDLE && ARVALID && ARREADY;
  end
  assign RDATA = r_err ? '0 : ram_q;
  axil_ram_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (w_state == W_COMMIT && aw_ok),
    .waddr (aw_word[IW-1:0]),
    .wdata (w_data),
    .wstrb (w_strb),
    .re    (rd_en),
    .raddr (ar_word[IW-1:0]),
    .rdata (ram_q)
  );
  // write FSM: collect AW and W in any order, commit for one cycle, then hold B until accepted
  always_ff @(posedge clk)
    if (rst) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b1;
      WREADY  <= 1'b1;
      BVALID  <= 1'b0;
      BRESP   <= RESP_OKAY;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID && AWREADY) begin
            aw_addr <= AWADDR;
            AWREADY <= 1'b0;
          end
          if (WVALID && WREADY) begin
            w_data <= WDATA;
            w_strb <= WSTRB;
            WREADY <= 1'b0;
          end
          if ((!AWREADY || AWVALID) && (!WREADY || WVALID)) w_state <= W_COMMIT;
        end
        W_COMMIT: begin
          w_state <= W_RESP;
          BVALID  <= 1'b1;
          BRESP   <= aw_ok ? RESP_OKAY : RESP_SLVERR;
        end
        W_RESP:
          if (BREADY) begin
            w_state <= W_IDLE;
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        default: w_state <= W_IDLE;
      endcase
    end
  // read FSM: the RAM read register doubles as RDATA, masked to zero for out-of-range reads
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RRESP   <= RESP_OKAY;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE:
          if (rd_en) begin
            r_state <= R_RESP;
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RRESP   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            r_err   <= !ar_ok;
          end
        R_RESP:
          if (RREADY) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b1;
            RVALID  <= 1'b0;
          end
        default: r_state <= R_IDLE;
      endcase
    end
endmodule
